// File: rtl/approx_mult_pkg.sv
// Shared definitions for the pipelined approximate multiplier: mode encoding
// and the reference column-truncation product used by the core and the bench model.
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Operands are zero-extended to 32 bits. Only columns >= trunc are summed.
  // Bit trunc-1 is then forced to 1 for non-zero operands, which roughly
  // re-centres the error of the dropped columns.
  function automatic logic [63:0] approx_product(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input int          width,
                                                 input int          trunc);
    logic [63:0] acc;
    logic [63:0] row;
    logic [63:0] mask;
    acc  = '0;
    mask = ~64'd0 << trunc;
    for (int i = 0; i < 32; i++) begin
      row = (i < width && b[i]) ? (64'(a) << i) : 64'd0;
      acc = acc + (row & mask);
    end
    if (a != '0 && b != '0) acc = acc | (64'd1 << (trunc - 1));
    return acc;
  endfunction

endpackage

// File: rtl/approx_mult_core.sv
// Combinational exact and column-truncated approximate products for one
// operand pair; the pipeline wrapper selects between them.
module approx_mult_core
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] exact,
  output logic [2*WIDTH-1:0] approx
);

  assign exact  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign approx = (2*WIDTH)'(approx_product(32'(a), 32'(b), WIDTH, TRUNC));

endmodule

// File: rtl/approx_mult_pipe.sv
// Elastic valid/ready pipeline around approx_mult_core with per-transaction mode.
// Optional error statistics are built when APPROX_MULT_ERR_STATS_EN is defined.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 4,
  parameter int STAGES = 3,
  parameter int ERRW   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*WIDTH-1:0]  out_y,
  output logic                out_mode,
  input  logic                stat_clr,
  output logic [ERRW-1:0]     stat_count,
  output logic [ERRW-1:0]     stat_err_sum
);

  localparam int PW = 2 * WIDTH;

  typedef struct packed {
    logic          mode;
    logic [PW-1:0] y;
`ifdef APPROX_MULT_ERR_STATS_EN
    logic [PW-1:0] exact;
`endif
  } stage_t;

  logic [PW-1:0]     exact_p;
  logic [PW-1:0]     approx_p;
  stage_t            in_pay;
  stage_t            pay_q [STAGES];
  stage_t            pay_d [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv;
  logic              in_fire;

  approx_mult_core #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_core (
    .a      (in_a),
    .b      (in_b),
    .exact  (exact_p),
    .approx (approx_p)
  );

  always_comb begin
    in_pay      = '0;
    in_pay.mode = in_mode;
    in_pay.y    = (in_mode == MODE_APPROX) ? approx_p : exact_p;
`ifdef APPROX_MULT_ERR_STATS_EN
    in_pay.exact = exact_p;
`endif
  end

  // A stage advances when it holds data and the stage after it can take it;
  // the chain is evaluated from the output back so in_ready sees out_ready.
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = v_q[STAGES-1] & out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~v_q[0] | adv[0];
  assign in_fire  = in_valid & in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    v_d   = v_q;
    pay_d = pay_q;
    if (~v_q[0] | adv[0]) begin
      v_d[0] = in_fire;
      if (in_fire) pay_d[0] = in_pay;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (~v_q[k] | adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) pay_d[k] = pay_q[k-1];
      end
    end
  end

  // NOTE: state uses non-blocking assignments; the payload is reset as well so
  // out_y/out_mode read 0 after reset rather than stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) pay_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      pay_q <= pay_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_y     = pay_q[STAGES-1].y;
  assign out_mode  = pay_q[STAGES-1].mode;

`ifdef APPROX_MULT_ERR_STATS_EN
  localparam int SW = ((ERRW > PW) ? ERRW : PW) + 1;

  logic            out_fire;
  logic [PW-1:0]   abs_err;
  logic [SW-1:0]   err_sum;
  logic [ERRW-1:0] cnt_q, cnt_d;
  logic [ERRW-1:0] err_q, err_d;

  assign out_fire = out_valid & out_ready;

  // The approximate result can exceed the exact one (forced bias bit), hence |.|.
  always_comb begin
    abs_err = (pay_q[STAGES-1].exact >= out_y) ? (pay_q[STAGES-1].exact - out_y)
                                               : (out_y - pay_q[STAGES-1].exact);
    err_sum = SW'(err_q) + SW'(abs_err);
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (stat_clr) begin
      cnt_d = '0;
      err_d = '0;
    end else if (out_fire && out_mode == MODE_APPROX) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + ERRW'(1);
      err_d = (err_sum > SW'({ERRW{1'b1}})) ? {ERRW{1'b1}} : ERRW'(err_sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stat_count   = cnt_q;
  assign stat_err_sum = err_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_count      = '0;
  assign stat_err_sum    = '0;
`endif

endmodule
